// File: rtl/aes_mem_pkg.sv
// Shared definitions for the AES-side storage RAMs: FSM state encoding,
// read/write strobe encoding and default geometry.
package aes_mem_pkg;

  // Controller states of the parametrised RAM
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // rw encoding kept identical to the legacy 4x8 RAM
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Geometry of the legacy RAM, used as parameter defaults
  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 8;

endpackage

// File: rtl/ram_sp_core.sv
// Bare single-port storage: one shared address, one write port and a
// registered read. No control logic, so it maps onto a block RAM; the
// output register's synchronous reset matches the RAM primitive's SSR.
module ram_sp_core
  import aes_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: the caller guarantees addr < DEPTH whenever en & we
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Registered read; holds its value on writes and idle cycles
  always_ff @(posedge clk) begin
    if (rst)             rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_sp_param.sv
// Parametrised single-port RAM for AES state/key storage. Wraps the bare
// storage core with a req/ready handshake, a clear sequencer (after reset
// or on clr), an address range check for non-power-of-two depths and
// one-cycle valid/err strobes.
module ram_sp_param
  import aes_mem_pkg::*;
#(
  parameter int              DATA_W      = DEF_DATA_W,
  parameter int              DEPTH       = DEF_DEPTH,
  parameter int              ADDR_W      = $clog2(DEPTH),
  parameter bit              RESET_CLEAR = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              err
);

  // Geometry sanity, caught at elaboration
  if (DATA_W < 1)               $error("DATA_W must be >= 1");
  if (DEPTH < 2)                $error("DEPTH must be >= 2");
  if (ADDR_W != $clog2(DEPTH))  $error("ADDR_W is derived, do not override");

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  // One extra bit so the compare also works when DEPTH == 2**ADDR_W
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  state_e              state;
  logic [ADDR_W-1:0]   cnt;

  logic                acc;
  logic                in_range;
  logic                rd_fire;
  logic                wr_fire;
  logic                bad_fire;

  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  // Handshake is decoded straight from the state register
  assign ready    = (state == ST_IDLE) && !rst;
  assign busy     = (state == ST_CLEAR);

  assign acc      = req && ready;
  assign in_range = {1'b0, addr} < DEPTH_X;
  assign rd_fire  = acc && (rw == RW_READ)  && in_range;
  assign wr_fire  = acc && (rw == RW_WRITE) && in_range;
  assign bad_fire = acc && !in_range;

  // Port mux: the clear sweep owns the RAM while busy; reset never writes
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr;
    mem_wdata = data_in;
    if (!rst) begin
      if (busy) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cnt;
        mem_wdata = CLEAR_VAL;
      end else begin
        mem_en    = rd_fire || wr_fire;
        mem_we    = wr_fire;
      end
    end
  end

  ram_sp_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (data_out)
  );

  // Controller: clear sweep of exactly DEPTH cycles, clr honoured only in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_CLEAR ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt   <= cnt + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          // an access accepted this cycle still completes before the sweep
          if (clr) state <= ST_CLEAR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One-cycle strobes for the access accepted at the previous edge
  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      data_valid <= rd_fire;
      err        <= bad_fire;
    end
  end

endmodule

// File: tb/tb_ram_sp_param.sv
// Bench for ram_sp_param: three instances (8x4 cleared to 0, 6x4 cleared
// to 3, 32x16 without reset clear) run in lockstep against an array model.
module tb_ram_sp_param;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i  [N];
  logic        req_i  [N];
  logic        rw_i   [N];
  logic        clr_i  [N];
  logic [4:0]  addr_i [N];
  logic [15:0] din_i  [N];

  logic        ready_o [N];
  logic        busy_o  [N];
  logic        valid_o [N];
  logic        err_o   [N];
  logic [15:0] dout_o  [N];

  logic [3:0]  d0, d1;
  logic [15:0] d2;
  assign dout_o[0] = {12'h000, d0};
  assign dout_o[1] = {12'h000, d1};
  assign dout_o[2] = d2;

  ram_sp_param #(.DATA_W(4), .DEPTH(8), .RESET_CLEAR(1'b1), .CLEAR_VAL(4'h0)) dut0 (
    .clk(clk), .rst(rst_i[0]), .req(req_i[0]), .rw(rw_i[0]), .addr(addr_i[0][2:0]),
    .data_in(din_i[0][3:0]), .clr(clr_i[0]), .ready(ready_o[0]), .busy(busy_o[0]),
    .data_out(d0), .data_valid(valid_o[0]), .err(err_o[0]));

  ram_sp_param #(.DATA_W(4), .DEPTH(6), .RESET_CLEAR(1'b1), .CLEAR_VAL(4'h3)) dut1 (
    .clk(clk), .rst(rst_i[1]), .req(req_i[1]), .rw(rw_i[1]), .addr(addr_i[1][2:0]),
    .data_in(din_i[1][3:0]), .clr(clr_i[1]), .ready(ready_o[1]), .busy(busy_o[1]),
    .data_out(d1), .data_valid(valid_o[1]), .err(err_o[1]));

  ram_sp_param #(.DATA_W(16), .DEPTH(32), .RESET_CLEAR(1'b0), .CLEAR_VAL(16'h0)) dut2 (
    .clk(clk), .rst(rst_i[2]), .req(req_i[2]), .rw(rw_i[2]), .addr(addr_i[2]),
    .data_in(din_i[2]), .clr(clr_i[2]), .ready(ready_o[2]), .busy(busy_o[2]),
    .data_out(d2), .data_valid(valid_o[2]), .err(err_o[2]));

  // Reference model: plain word array, "known" flags, remaining clear cycles
  logic [15:0] mm [N][32];
  bit          kn [N][32];
  int          cl [N];
  logic [15:0] dm [N];
  bit          dk [N];
  bit          vm [N];
  bit          em [N];

  int checks   = 0;
  int failures = 0;

  function automatic int dep(input int k);
    return (k == 0) ? 8 : (k == 1) ? 6 : 32;
  endfunction
  function automatic int aw(input int k);
    return (k == 2) ? 5 : 3;
  endfunction
  function automatic logic [15:0] msk(input int k);
    return (k == 2) ? 16'hFFFF : 16'h000F;
  endfunction
  function automatic logic [15:0] cval(input int k);
    return (k == 1) ? 16'h0003 : 16'h0000;
  endfunction
  function automatic bit rclr(input int k);
    return k != 2;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < N; k++) begin
      rst_i[k] = 1'b0; req_i[k] = 1'b0; rw_i[k] = 1'b0;
      clr_i[k] = 1'b0; addr_i[k] = '0;  din_i[k] = '0;
    end
  endtask

  task automatic op(input int k, input bit r, input bit rq, input bit w,
                    input int a, input logic [15:0] d, input bit c);
    rst_i[k] = r; req_i[k] = rq; rw_i[k] = w;
    addr_i[k] = 5'(a); din_i[k] = d & msk(k); clr_i[k] = c;
  endtask

  // One clock for all instances: handshake check, edge, model step, output check
  task automatic tick();
    int a;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("ready", k, ready_o[k], (!rst_i[k] && cl[k] == 0));
      chk("busy",  k, busy_o[k],  (cl[k] != 0));
    end
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      vm[k] = 0; em[k] = 0;
      if (rst_i[k]) begin
        dm[k] = '0; dk[k] = 1;
        cl[k] = rclr(k) ? dep(k) : 0;
      end else if (cl[k] != 0) begin
        a = dep(k) - cl[k];
        mm[k][a] = cval(k); kn[k][a] = 1;
        cl[k]--;
      end else begin
        if (req_i[k]) begin
          a = int'(addr_i[k]);
          if (a >= dep(k)) em[k] = 1;
          else if (rw_i[k]) begin vm[k] = 1; dm[k] = mm[k][a]; dk[k] = kn[k][a]; end
          else begin mm[k][a] = din_i[k]; kn[k][a] = 1; end
        end
        if (clr_i[k]) cl[k] = dep(k);
      end
    end
    #1;
    for (int k = 0; k < N; k++) begin
      chk("data_valid", k, valid_o[k], vm[k]);
      chk("err",        k, err_o[k],   em[k]);
      if (dk[k]) chk("data_out", k, dout_o[k], dm[k]);
    end
    idle_all();
  endtask

  // Counts busy cycles from the current (post-edge) sample, bounded
  task automatic count_busy(input int k, output int n);
    n = 0;
    for (int i = 0; i < 80 && busy_o[k]; i++) begin
      n++;
      tick();
    end
  endtask

  typedef struct {
    logic        req;
    logic        rw;
    logic [4:0]  addr;
    logic [15:0] din;
    logic        ev;
    logic        ee;
    logic [15:0] ed;
  } vec_t;

  vec_t vt [12];

  initial begin
    int n, r;

    vt[0]  = '{1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 16'h0};
    vt[1]  = '{1'b1, 1'b0, 5'd1, 16'h1, 1'b0, 1'b0, 16'h0};
    vt[2]  = '{1'b1, 1'b0, 5'd2, 16'h2, 1'b0, 1'b0, 16'h0};
    vt[3]  = '{1'b1, 1'b0, 5'd3, 16'h3, 1'b0, 1'b0, 16'h0};
    vt[4]  = '{1'b1, 1'b1, 5'd0, 16'h0, 1'b1, 1'b0, 16'h0};
    vt[5]  = '{1'b1, 1'b1, 5'd1, 16'h0, 1'b1, 1'b0, 16'h1};
    vt[6]  = '{1'b1, 1'b1, 5'd2, 16'h0, 1'b1, 1'b0, 16'h2};
    vt[7]  = '{1'b1, 1'b1, 5'd3, 16'h0, 1'b1, 1'b0, 16'h3};
    vt[8]  = '{1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 16'h3};
    vt[9]  = '{1'b1, 1'b0, 5'd7, 16'hC, 1'b0, 1'b0, 16'h3};
    vt[10] = '{1'b1, 1'b1, 5'd7, 16'h0, 1'b1, 1'b0, 16'hC};
    vt[11] = '{1'b1, 1'b1, 5'd3, 16'h0, 1'b1, 1'b0, 16'h3};

    idle_all();
    for (int k = 0; k < N; k++) rst_i[k] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      cl[k] = rclr(k) ? dep(k) : 0;
      dm[k] = '0; dk[k] = 1; vm[k] = 0; em[k] = 0;
      for (int a = 0; a < 32; a++) begin mm[k][a] = '0; kn[k][a] = 0; end
    end
    idle_all();

    // Reset restarts the sweep: busy for exactly DEPTH cycles
    op(0, 1, 0, 0, 0, 0, 0);
    tick();
    chk("rst_dout", 0, dout_o[0], 0);
    count_busy(0, n);
    chk("clear_len_rst", 0, n, 8);

    // Every word reads back as the clear value with latency 1
    for (int a = 0; a < 8; a++) begin
      op(0, 0, 1, 1, a, 0, 0);
      tick();
      chk("rd_cleared_v", 0, valid_o[0], 1);
      chk("rd_cleared_d", 0, dout_o[0], 0);
    end

    // Table: writes then back-to-back reads
    for (int i = 0; i < 12; i++) begin
      op(0, 0, vt[i].req, vt[i].rw, int'(vt[i].addr), vt[i].din, 0);
      tick();
      chk("vec_valid", i, valid_o[0], vt[i].ev);
      chk("vec_err",   i, err_o[0],   vt[i].ee);
      chk("vec_dout",  i, dout_o[0],  vt[i].ed);
    end

    // clr together with a read: pre-clear data returned, then full sweep
    op(0, 0, 1, 0, 2, 16'hA, 0); tick();
    op(0, 0, 1, 1, 2, 0, 1);     tick();
    chk("clr_rd_valid", 0, valid_o[0], 1);
    chk("clr_rd_dout",  0, dout_o[0], 16'hA);
    count_busy(0, n);
    chk("clear_len_clr", 0, n, 8);
    op(0, 0, 1, 1, 2, 0, 0); tick();
    chk("post_clr_dout", 0, dout_o[0], 0);

    // Reset in the middle of a sweep (cnt=3) restarts it from the top
    op(0, 0, 1, 0, 1, 16'h5, 0); tick();
    op(0, 0, 1, 1, 1, 0, 0);     tick();
    chk("pre_rst_dout", 0, dout_o[0], 5);
    op(0, 0, 0, 0, 0, 0, 1);     tick();
    repeat (3) tick();
    op(0, 1, 0, 0, 0, 0, 0);     tick();
    chk("mid_rst_dout",  0, dout_o[0], 0);
    chk("mid_rst_valid", 0, valid_o[0], 0);
    count_busy(0, n);
    chk("clear_len_mid", 0, n, 8);

    // DEPTH=6: out-of-range accesses flag err and leave memory/output alone
    count_busy(1, n);
    chk("wait_idle", 1, busy_o[1], 0);
    op(1, 0, 1, 0, 5, 16'h9, 0); tick();
    op(1, 0, 1, 1, 5, 0, 0);     tick();
    chk("d6_rd5", 1, dout_o[1], 9);
    op(1, 0, 1, 0, 7, 16'hF, 0); tick();
    chk("d6_wr7_err", 1, err_o[1], 1);
    op(1, 0, 1, 1, 7, 0, 0);     tick();
    chk("d6_rd7_err",   1, err_o[1], 1);
    chk("d6_rd7_valid", 1, valid_o[1], 0);
    chk("d6_rd7_dout",  1, dout_o[1], 9);
    op(1, 0, 1, 1, 5, 0, 0);     tick();
    chk("d6_rd5_again", 1, dout_o[1], 9);
    op(1, 0, 1, 1, 4, 0, 0);     tick();
    chk("d6_rd4_clrval", 1, dout_o[1], 3);

    // No reset clear: ready right after reset, full-width word at top address
    op(2, 1, 0, 0, 0, 0, 0); tick();
    #1;
    chk("nc_ready", 2, ready_o[2], 1);
    op(2, 0, 1, 0, 31, 16'hBEEF, 0); tick();
    op(2, 0, 1, 1, 31, 0, 0);        tick();
    chk("nc_valid", 2, valid_o[2], 1);
    chk("nc_dout",  2, dout_o[2], 16'hBEEF);

    // Random traffic on all three instances
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) begin
        r = int'($urandom_range(0, 511));
        op(k, (r == 0), (r % 4) != 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, (1 << aw(k)) - 1)), 16'($urandom), (r > 1 && r < 10));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
